// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one 512-bit memory command port among NUM_REQ engines.
// Outstanding reads are tracked by requester ID in an in-order tag FIFO to steer returns.
module mem_port_arbiter #(
  parameter int unsigned NUM_REQ         = 2,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned ID_W            = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_rvalid,
  input  logic [NUM_REQ-1:0]               req_wvalid,
  input  logic [NUM_REQ*30-1:0]            req_raddr,
  input  logic [NUM_REQ*30-1:0]            req_waddr,
  input  logic [NUM_REQ*512-1:0]           req_wdata,
  output logic [NUM_REQ-1:0]               req_gnt,
  output logic [511:0]                     req_rdata,
  output logic [NUM_REQ-1:0]               req_rddata_valid,
  output logic [29:0]                      mem_raddr,
  output logic [29:0]                      mem_waddr,
  output logic [511:0]                     mem_wdata,
  output logic                             mem_rvalid,
  output logic                             mem_wvalid,
  input  logic                             mem_ready,
  input  logic [511:0]                     mem_rdata,
  input  logic                             mem_rddata_valid,
  output logic                             proto_err,
  output logic [$clog2(MAX_OUTSTANDING):0] rd_outstanding
);
  localparam int unsigned AW = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CW = AW + 1;

  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q, count_d;
  logic [ID_W-1:0]    tag_q [MAX_OUTSTANDING];
  logic               mem_rvalid_q, mem_wvalid_q;
  logic [29:0]        mem_raddr_q, mem_waddr_q;
  logic [511:0]       mem_wdata_q;
  logic               proto_err_q, proto_err_d;

  logic               fifo_full, fifo_empty, can_grant;
  logic [NUM_REQ-1:0] eligible, gnt_oh;
  logic               gnt_found, grant_fire, gnt_write, gnt_both;
  logic [ID_W-1:0]    gnt_idx, head_id;
  logic [29:0]        gnt_raddr, gnt_waddr;
  logic [511:0]       gnt_wdata;
  logic               push, pop, spurious, rd_full_err;

  assign fifo_full  = (count_q == CW'(MAX_OUTSTANDING));
  assign fifo_empty = (count_q == '0);
  assign can_grant  = !(mem_rvalid_q || mem_wvalid_q) || mem_ready;

  // A write (including the both-valids case) never consumes a tag, so only pure reads see the limit.
  always_comb begin
    eligible = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      eligible[j] = req_wvalid[j] || (req_rvalid[j] && !fifo_full);
    end
  end

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!gnt_found && eligible[j] && (j == (32'(rr_ptr_q) + i) % NUM_REQ)) begin
          gnt_found = 1'b1;
          gnt_idx   = ID_W'(j);
        end
      end
    end
  end

  assign grant_fire = gnt_found && can_grant && !rst;

  always_comb begin
    gnt_oh    = '0;
    gnt_raddr = '0;
    gnt_waddr = '0;
    gnt_wdata = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      gnt_oh[j] = grant_fire && (gnt_idx == ID_W'(j));
      if (gnt_oh[j]) begin
        gnt_raddr = req_raddr[j*30 +: 30];
        gnt_waddr = req_waddr[j*30 +: 30];
        gnt_wdata = req_wdata[j*512 +: 512];
      end
    end
  end

  assign gnt_write   = |(gnt_oh & req_wvalid);
  assign gnt_both    = |(gnt_oh & req_wvalid & req_rvalid);
  assign push        = grant_fire && !gnt_write && !fifo_full;
  assign rd_full_err = grant_fire && !gnt_write && fifo_full;
  assign pop         = mem_rddata_valid && !fifo_empty;
  assign spurious    = mem_rddata_valid && fifo_empty;
  assign head_id     = tag_q[rd_ptr_q];

  always_comb begin
    req_rddata_valid = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      req_rddata_valid[j] = pop && (head_id == ID_W'(j));
    end
  end

  assign rr_ptr_d    = grant_fire ? gnt_idx : rr_ptr_q;
  assign count_d     = count_q + CW'(push) - CW'(pop);
  assign proto_err_d = proto_err_q || (grant_fire && gnt_both) || spurious || rd_full_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q     <= ID_W'(NUM_REQ - 1);
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      proto_err_q  <= 1'b0;
      mem_rvalid_q <= 1'b0;
      mem_wvalid_q <= 1'b0;
      mem_raddr_q  <= '0;
      mem_waddr_q  <= '0;
      mem_wdata_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      count_q     <= count_d;
      proto_err_q <= proto_err_d;
      if (push) begin
        tag_q[wr_ptr_q] <= gnt_idx;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      // A grant only happens when the register is free or being accepted, so reload wins over clear.
      if (grant_fire) begin
        mem_rvalid_q <= !gnt_write;
        mem_wvalid_q <= gnt_write;
        if (gnt_write) begin
          mem_waddr_q <= gnt_waddr;
          mem_wdata_q <= gnt_wdata;
        end else begin
          mem_raddr_q <= gnt_raddr;
        end
      end else if (mem_ready) begin
        mem_rvalid_q <= 1'b0;
        mem_wvalid_q <= 1'b0;
      end
    end
  end

  assign req_gnt        = gnt_oh;
  assign req_rdata      = mem_rdata;
  assign mem_raddr      = mem_raddr_q;
  assign mem_waddr      = mem_waddr_q;
  assign mem_wdata      = mem_wdata_q;
  assign mem_rvalid     = mem_rvalid_q;
  assign mem_wvalid     = mem_wvalid_q;
  assign proto_err      = proto_err_q;
  assign rd_outstanding = count_q;

  a_single_grant: assert property (@(posedge clk) $onehot0(req_gnt));
  a_no_full_push: assert property (@(posedge clk) disable iff (rst) !rd_full_err);

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter that shares the single 512-bit memory port (30-bit read/write addresses, rvalid/wvalid/ready, rdata with rddata_valid) between NUM_REQ client engines. It sits between the compute engines and the memory controller or memory model. It issues at most one command per cycle and records the requester ID of every outstanding read in an in-order tag FIFO. Each returning rddata_valid beat is steered back to the requester that issued the read.

## Interface
Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..8.
- MAX_OUTSTANDING, 8, maximum number of reads in flight; power of two, 2..64.
- ID_W, 3, requester-ID width; ≥ clog2(NUM_REQ).

Ports:
- clk  in  1  single clock; all logic is on posedge.
- rst  in  1  synchronous, active-high reset.
- req_rvalid  in  NUM_REQ  per-requester read request.
- req_wvalid  in  NUM_REQ  per-requester write request.
- req_raddr  in  NUM_REQ*30  packed read addresses; requester i uses bits [30i+29:30i].
- req_waddr  in  NUM_REQ*30  packed write addresses.
- req_wdata  in  NUM_REQ*512  packed write data.
- req_gnt  out  NUM_REQ  one-hot grant, combinational; the request is accepted in the cycle req_gnt[i] is high.
- req_rdata  out  512  read data, broadcast to all requesters.
- req_rddata_valid  out  NUM_REQ  one-hot read-return strobe.
- mem_raddr  out  30  memory read address.
- mem_waddr  out  30  memory write address.
- mem_wdata  out  512  memory write data.
- mem_rvalid  out  1  memory read strobe.
- mem_wvalid  out  1  memory write strobe.
- mem_ready  in  1  memory accepts the command presented this cycle.
- mem_rdata  in  512  memory read data.
- mem_rddata_valid  in  1  memory read-return strobe; returns are in order.
- proto_err  out  1  sticky protocol-error flag.
- rd_outstanding  out  clog2(MAX_OUTSTANDING)+1  number of reads in flight.

## Operation
- **Request:** requester i is requesting when req_rvalid[i] | req_wvalid[i]. It holds its request and its address/data stable until granted.
- **Both valids:** if req_rvalid[i] and req_wvalid[i] are high together, the grant issues the write only, the read is dropped, and proto_err is set.
- **Eligibility:** requester i is eligible when it is requesting, and, for a read, rd_outstanding + pending_issue_read < MAX_OUTSTANDING. A requester with a read blocked by this limit is skipped; lower-priority requesters may still be granted.
- **Round-robin:** rr_ptr names the last granted requester. Priority order is rr_ptr+1, rr_ptr+2, … modulo NUM_REQ. rr_ptr updates only on a grant.
- **Command register:**
  - A grant occurs only when the output register is empty, or it holds a command and mem_ready=1 in that cycle.
  - On a grant, the granted address, data and type load into the output register on the next edge.
  - mem_rvalid/mem_wvalid stay high until a cycle with mem_ready=1 and are then cleared, unless a new grant reloads the register.
- **Tag FIFO:**
  - Each read is pushed (requester ID) when the grant occurs, not when the memory accepts it.
  - Each mem_rddata_valid pops one entry.
  - req_rddata_valid = onehot(head ID) & mem_rddata_valid, combinational; req_rdata = mem_rdata, combinational.
  - A simultaneous push and pop leaves the count unchanged.
  - The read and write pointers wrap modulo MAX_OUTSTANDING.
- **rd_outstanding:** equals the tag FIFO count (granted reads not yet returned).
- **proto_err** is sticky until rst. It is set by any of:
  - both valids high on a granted requester;
  - mem_rddata_valid while the tag FIFO is empty (that pop is ignored and no req_rddata_valid fires);
  - a read grant attempted while the FIFO is full (unreachable when eligibility is correct; kept as an assertion).

## Timing
- **Reset values** (all outputs and state):
  - req_gnt = 0, req_rddata_valid = 0.
  - mem_rvalid = 0, mem_wvalid = 0; mem_raddr, mem_waddr, mem_wdata = 0.
  - proto_err = 0, rd_outstanding = 0.
  - rr_ptr = NUM_REQ-1, so requester 0 has first priority.
  - Tag FIFO empty.
- **Reset mid-operation:** in-flight reads are forgotten. Returns arriving after rst falls with an empty FIFO set proto_err; the bench must reset memory and arbiter together.
- **Latency:** grant in cycle T puts the command on the mem_* outputs in T+1. With a 1-cycle memory (data on the edge after the strobe, mem_ready=1), req_rddata_valid rises in T+2.
- **Throughput:** one command per cycle while mem_ready=1. With mem_ready=0 there are no new grants until the pending command is accepted.
- **Requester handshake:** the requester may change its request the cycle after req_gnt.
- **Single grant:** req_gnt has at most one bit high per cycle (required invariant).

## Test plan
- **Round-robin fairness:** all 4 requesters (NUM_REQ=4) issue continuous reads with mem_ready=1 -> grants in order 0,1,2,3,0,…. Each req_rddata_valid[i] arrives 2 cycles after req_gnt[i], carrying memory[addr] for that requester's address.
- **Write then read, same address:** requester 1 writes 0x5A…5A to addr 0x10, then requester 2 reads 0x10 -> req_rddata_valid[2] with rdata 0x5A…5A; req_rddata_valid[1] never fires.
- **Backpressure:** mem_ready held low for 5 cycles during a command -> mem_* outputs stable all 5 cycles, no req_gnt, no duplicate issue. Stream resumes in order when mem_ready=1.
- **Outstanding limit:** MAX_OUTSTANDING=2, memory returns delayed 10 cycles, requester 0 reads continuously and requester 1 writes -> requester 0 is granted twice then blocked, requester 1 writes still granted, rd_outstanding never exceeds 2. After each return requester 0 is granted again.
- **Protocol errors:**
  - requester 3 asserts both valids -> a write is issued and proto_err=1;
  - separately after rst, a spurious mem_rddata_valid with an empty FIFO -> proto_err=1 and req_rddata_valid stays 0.
- **Reset mid-stream:** rst asserted with 3 reads outstanding -> next cycle rd_outstanding=0, all outputs at reset values, and the first grant after reset goes to requester 0.
